led_serial_rx: RTL and testbench

Serial-to-parallel receiver for the board LED shift-chain protocol, MSB first, one bit per rising serial clock, active-low clear, high output-enable. It is the receiving end of the LED serial driver and is used for on-chip loopback self-test and for daughter-board emulation. It synchronizes the serial lines into the system clock, detects serial clock edges, deserializes WIDTH bits, and presents a latched parallel word with a one-cycle frame strobe and an error strobe.

---
 rtl/led_serial_rx.sv | 189 ++++++++++++++++++
 tb/tb_led_serial_rx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/led_serial_rx.sv
// Receiving end of the LED shift-chain: synchronizes the serial lines, deserializes WIDTH bits MSB first
// and presents a latched word with frame/error strobes. Define LED_RX_INVERT_EN to complement each sampled bit.
module led_serial_rx #(
  parameter int WIDTH    = 16,
  parameter int IDLE_CYC = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ser_do,
  input  logic             ser_clk,
  input  logic             ser_clr,
  input  logic             ser_pen,
  output logic [WIDTH-1:0] led,
  output logic             frame_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int IDL_W = $clog2(IDLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
  localparam logic [IDL_W-1:0] IDLE_MAX = IDL_W'(IDLE_CYC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_DONE,
    S_HOLD
  } state_t;

  // Line polarity: the driver may send complemented data (LED on = line low).
  function automatic logic sample_bit(input logic line);
`ifdef LED_RX_INVERT_EN
    return ~line;
`else
    return line;
`endif
  endfunction

  // Stage p0/p1: two-flop synchronizers; p2 holds the previous synchronized serial clock.
  logic ser_do_p0, ser_do_p1;
  logic ser_clk_p0, ser_clk_p1, ser_clk_p2;
  logic ser_clr_p0, ser_clr_p1;
  logic ser_pen_p0, ser_pen_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ser_do_p0  <= 1'b0;
      ser_do_p1  <= 1'b0;
      ser_clk_p0 <= 1'b0;
      ser_clk_p1 <= 1'b0;
      ser_clk_p2 <= 1'b0;
      ser_clr_p0 <= 1'b0;
      ser_clr_p1 <= 1'b0;
      ser_pen_p0 <= 1'b0;
      ser_pen_p1 <= 1'b0;
    end else begin
      ser_do_p0  <= ser_do;
      ser_do_p1  <= ser_do_p0;
      ser_clk_p0 <= ser_clk;
      ser_clk_p1 <= ser_clk_p0;
      ser_clk_p2 <= ser_clk_p1;
      ser_clr_p0 <= ser_clr;
      ser_clr_p1 <= ser_clr_p0;
      ser_pen_p0 <= ser_pen;
      ser_pen_p1 <= ser_pen_p0;
    end
  end

  // Edges seen while the chain is held in clear are discarded outright.
  logic clr_act, edge_p2, bit_p2;
  assign clr_act = ~ser_clr_p1;
  assign edge_p2 = ser_clk_p1 & ~ser_clk_p2 & ~clr_act;
  assign bit_p2  = sample_bit(ser_do_p1);

  logic [IDL_W-1:0] idle_cnt;
  logic             idle_to;
  assign idle_to = (idle_cnt == IDLE_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
    end else if (edge_p2) begin
      idle_cnt <= '0;
    end else if (!idle_to) begin
      idle_cnt <= idle_cnt + IDL_W'(1);
    end
  end

  // Stage p3: frame state machine and output registers.
  state_t           state, state_nx;
  logic [WIDTH-1:0] sh, sh_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             exc, exc_nx;
  logic [WIDTH-1:0] led_nx;
  logic             fv_nx, fe_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      sh          <= '0;
      cnt         <= '0;
      exc         <= 1'b0;
      led         <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      sh          <= sh_nx;
      cnt         <= cnt_nx;
      exc         <= exc_nx;
      led         <= led_nx;
      frame_valid <= fv_nx;
      frame_err   <= fe_nx;
      busy        <= (state_nx != S_IDLE);
    end
  end

  always_comb begin
    state_nx = state;
    sh_nx    = sh;
    cnt_nx   = cnt;
    exc_nx   = exc;
    led_nx   = led;
    fv_nx    = 1'b0;
    fe_nx    = 1'b0;
    if (clr_act) begin
      state_nx = S_IDLE;
      sh_nx    = '0;
      cnt_nx   = '0;
      exc_nx   = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (edge_p2) begin
            sh_nx    = {{(WIDTH-1){1'b0}}, bit_p2};
            cnt_nx   = CNT_W'(1);
            exc_nx   = 1'b0;
            state_nx = S_RECV;
          end
        end
        S_RECV: begin
          if (edge_p2) begin
            sh_nx  = {sh[WIDTH-2:0], bit_p2};
            cnt_nx = cnt + CNT_W'(1);
            if ((cnt + CNT_W'(1)) == CNT_MAX) begin
              state_nx = S_DONE;
            end
          end else if (idle_to) begin
            fe_nx    = 1'b1;
            cnt_nx   = '0;
            state_nx = S_IDLE;
          end
        end
        S_DONE: begin
          if (ser_pen_p1) begin
            led_nx = sh;
          end
          fv_nx    = 1'b1;
          state_nx = S_HOLD;
          if (edge_p2) begin
            exc_nx = 1'b1;
            if (cnt != CNT_MAX) begin
              cnt_nx = cnt + CNT_W'(1);
            end
          end
        end
        S_HOLD: begin
          if (edge_p2) begin
            exc_nx = 1'b1;
            if (cnt != CNT_MAX) begin
              cnt_nx = cnt + CNT_W'(1);
            end
          end else if (idle_to) begin
            fe_nx    = exc;
            cnt_nx   = '0;
            exc_nx   = 1'b0;
            state_nx = S_IDLE;
          end
        end
        default: begin
          state_nx = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_serial_rx.sv
// Directed bench for led_serial_rx: hand-computed frames, strobe counts and timeout latency.
module tb_led_serial_rx;

  localparam int WIDTH    = 16;
  localparam int IDLE_CYC = 20;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             ser_do = 1'b0;
  logic             ser_clk = 1'b0;
  logic             ser_clr = 1'b1;
  logic             ser_pen = 1'b1;
  logic [WIDTH-1:0] led;
  logic             frame_valid;
  logic             frame_err;
  logic             busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fv_n = 0;
  int fe_n = 0;
  int fe_cyc = 0;
  int last_rise = 0;

  led_serial_rx #(.WIDTH(WIDTH), .IDLE_CYC(IDLE_CYC)) dut (
    .clk(clk), .reset(reset), .ser_do(ser_do), .ser_clk(ser_clk),
    .ser_clr(ser_clr), .ser_pen(ser_pen), .led(led),
    .frame_valid(frame_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_valid) fv_n++;
    if (frame_err) begin
      fe_n++;
      fe_cyc = cyc;
    end
  end

  function automatic logic line_of(input logic b);
`ifdef LED_RX_INVERT_EN
    return ~b;
`else
    return b;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends v[n-1] first; 4 clk low with data set up, then 4 clk high.
  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(posedge clk); #1;
      ser_clk = 1'b0;
      ser_do  = line_of(v[i]);
      repeat (4) @(posedge clk);
      #1;
      ser_clk   = 1'b1;
      last_rise = cyc;
      repeat (4) @(posedge clk);
    end
  endtask

  task automatic quiet();
    repeat (IDLE_CYC + 12) @(posedge clk);
    #1;
  endtask

  int fv0, fe0;

  initial begin
    // Reset held with random serial activity
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      ser_do  = 1'($urandom_range(0, 1));
      ser_clk = 1'($urandom_range(0, 1));
      ser_clr = 1'($urandom_range(0, 1));
      ser_pen = 1'($urandom_range(0, 1));
      if (i % 8 == 7) begin
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_strobes", {29'd0, frame_valid, frame_err, busy}, 32'h0);
      end
    end
    ser_clk = 1'b0; ser_clr = 1'b1; ser_pen = 1'b1; ser_do = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_fv_cnt", 32'(fv_n), 32'd0);

    // Frame 0xA5C3
    fv0 = fv_n; fe0 = fe_n;
    send_bits(32'hA5C3, 16);
    repeat (4) @(posedge clk);
    #1;
    chk("a5c3_led", 32'(led), 32'hA5C3);
    chk("a5c3_fv", 32'(fv_n - fv0), 32'd1);
    quiet();
    chk("a5c3_fe", 32'(fe_n - fe0), 32'd0);
    chk("a5c3_busy", 32'(busy), 32'd0);

    // 0x1234 accepted, then 0xFFFF with output enable low
    fv0 = fv_n; fe0 = fe_n;
    send_bits(32'h1234, 16);
    quiet();
    chk("1234_led", 32'(led), 32'h1234);
    ser_pen = 1'b0;
    send_bits(32'hFFFF, 16);
    quiet();
    chk("pen0_led", 32'(led), 32'h1234);
    chk("pen0_fv", 32'(fv_n - fv0), 32'd2);
    chk("pen0_fe", 32'(fe_n - fe0), 32'd0);
    ser_pen = 1'b1;

    // Short frame of 10 edges
    fv0 = fv_n; fe0 = fe_n;
    send_bits(32'h2AA, 10);
    chk("short_busy_mid", 32'(busy), 32'd1);
    quiet();
    chk("short_fe", 32'(fe_n - fe0), 32'd1);
    chk("short_fe_lat", 32'(fe_cyc - last_rise), 32'(IDLE_CYC + 4));
    chk("short_fv", 32'(fv_n - fv0), 32'd0);
    chk("short_led", 32'(led), 32'h1234);
    chk("short_busy", 32'(busy), 32'd0);

    // Long frame of 18 edges: first 16 bits are 0xC3A5
    fv0 = fv_n; fe0 = fe_n;
    send_bits({14'd0, 16'hC3A5, 2'b10}, 18);
    chk("long_led", 32'(led), 32'hC3A5);
    chk("long_fv", 32'(fv_n - fv0), 32'd1);
    chk("long_fe_early", 32'(fe_n - fe0), 32'd0);
    quiet();
    chk("long_fe", 32'(fe_n - fe0), 32'd1);
    chk("long_busy", 32'(busy), 32'd0);

    // Clear after 8 bits, then full 0x00FF
    fv0 = fv_n; fe0 = fe_n;
    send_bits(32'hF0, 8);
    @(posedge clk); #1 ser_clr = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_led", 32'(led), 32'hC3A5);
    ser_clr = 1'b1;
    repeat (4) @(posedge clk);
    send_bits(32'h00FF, 16);
    quiet();
    chk("clr_then_led", 32'(led), 32'h00FF);
    chk("clr_fv", 32'(fv_n - fv0), 32'd1);
    chk("clr_fe", 32'(fe_n - fe0), 32'd0);

    // Reset mid-frame after 12 bits of 0xBEEF
    send_bits(32'hBEE, 12);
    chk("mid_busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_led", 32'(led), 32'h0);
    chk("mid_rst_strobes", {29'd0, frame_valid, frame_err, busy}, 32'h0);
    ser_clk = 1'b0; ser_do = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (5) @(posedge clk);
    fv0 = fv_n; fe0 = fe_n;
    send_bits(32'hBEEF, 16);
    quiet();
    chk("beef_led", 32'(led), 32'hBEEF);
    chk("beef_fv", 32'(fv_n - fv0), 32'd1);
    chk("beef_fe", 32'(fe_n - fe0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
